// File: rtl/bus_pkg.sv
// Shared definitions for the bus device interface: destination field layout,
// broadcast address, default packet type and a destination-extraction helper.
package bus_pkg;

    localparam int DEST_W       = 8;
    localparam logic [DEST_W-1:0] BCAST_ID = 8'hFF;
    localparam int PCKG_SZ_DFLT = 16;
    localparam int PKT_MAX_W    = 64;

    typedef logic [PCKG_SZ_DFLT-1:0] pkt_t;

    // Destination ID sits in the top DEST_W bits of a packet of width pkt_w.
    // The packet is passed zero-extended so one helper serves every width.
    function automatic logic [DEST_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                                  input int unsigned pkt_w);
        logic [PKT_MAX_W-1:0] shifted_s;
        shifted_s = pkt >> (pkt_w - DEST_W);
        return shifted_s[DEST_W-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. A read on a full FIFO frees the slot for a
// same-cycle write; a read on an empty FIFO is ignored and flagged.
module sync_fifo #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [width-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [width-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(depth):0]   count,
    output logic                     ovf,
    output logic                     udf
);

    localparam int AW = $clog2(depth);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(depth);

    logic [width-1:0] mem_r [depth];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_wr_s;
    logic             do_rd_s;
    logic             empty_s;
    logic             full_s;

    // Qualify requests against occupancy and present the show-ahead head.
    always_comb begin
        empty_s = 1'b0;
        full_s  = 1'b0;
        do_rd_s = 1'b0;
        do_wr_s = 1'b0;
        ovf     = 1'b0;
        udf     = 1'b0;
        rd_data = {width{1'b0}};
        empty_s = (count_r == {(AW+1){1'b0}});
        full_s  = (count_r == FULL_CNT);
        do_rd_s = rd_en && !empty_s;
        do_wr_s = wr_en && (!full_s || do_rd_s);
        ovf     = wr_en && full_s && !do_rd_s;
        udf     = rd_en && empty_s;
        if (!empty_s) begin
            rd_data = mem_r[rd_ptr_r];
        end else begin
            rd_data = {width{1'b0}};
        end
    end

    assign full  = full_s;
    assign empty = empty_s;
    assign count = count_r;

    // Storage, pointers and occupancy; pointers wrap at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) begin
                mem_r[i] <= {width{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_wr_s) begin
                mem_r[wr_ptr_r] <= wr_data;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/bus_dev_fifo.sv
// Per-device bus interface: TX FIFO toward the arbiter, destination-filtered
// RX FIFO from the arbiter, sticky error flags and a misaddressed-drop counter.
module bus_dev_fifo
    import bus_pkg::*;
#(
    parameter int               pckg_sz   = 16,
    parameter int               depth     = 8,
    parameter logic [DEST_W-1:0] id        = 8'h00,
    parameter logic [DEST_W-1:0] broadcast = BCAST_ID
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dev_wr_en,
    input  logic [pckg_sz-1:0]       dev_wr_data,
    output logic                     tx_full,
    output logic [$clog2(depth):0]   tx_count,
    output logic                     pndng,
    output logic [pckg_sz-1:0]       D_pop,
    input  logic                     pop,
    input  logic                     push,
    input  logic [pckg_sz-1:0]       D_push,
    input  logic                     dev_rd_en,
    output logic [pckg_sz-1:0]       dev_rd_data,
    output logic                     rx_valid,
    output logic [$clog2(depth):0]   rx_count,
    input  logic                     clr_status,
    output logic                     tx_ovf,
    output logic                     tx_udf,
    output logic                     rx_ovf,
    output logic [7:0]               rx_drop_cnt
);

    logic              tx_empty_s;
    logic              tx_ovf_ev_s;
    logic              tx_udf_ev_s;
    logic              rx_empty_s;
    logic              rx_full_s;
    logic              rx_ovf_ev_s;
    logic              rx_udf_ev_s;
    logic              rx_match_s;
    logic              rx_accept_s;
    logic              drop_ev_s;
    logic [DEST_W-1:0] rx_dest_s;
    logic              tx_ovf_r;
    logic              tx_udf_r;
    logic              rx_ovf_r;
    logic [7:0]        drop_cnt_r;

    sync_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (dev_wr_en),
        .wr_data (dev_wr_data),
        .rd_en   (pop),
        .rd_data (D_pop),
        .full    (tx_full),
        .empty   (tx_empty_s),
        .count   (tx_count),
        .ovf     (tx_ovf_ev_s),
        .udf     (tx_udf_ev_s)
    );

    // Destination filter: only packets for this device or broadcast enter RX.
    always_comb begin
        rx_dest_s   = {DEST_W{1'b0}};
        rx_match_s  = 1'b0;
        rx_accept_s = 1'b0;
        drop_ev_s   = 1'b0;
        rx_dest_s   = dest_of(PKT_MAX_W'(D_push), pckg_sz);
        rx_match_s  = (rx_dest_s == id) || (rx_dest_s == broadcast);
        if (push) begin
            rx_accept_s = rx_match_s;
            drop_ev_s   = !rx_match_s;
        end else begin
            rx_accept_s = 1'b0;
            drop_ev_s   = 1'b0;
        end
    end

    sync_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (rx_accept_s),
        .wr_data (D_push),
        .rd_en   (dev_rd_en),
        .rd_data (dev_rd_data),
        .full    (rx_full_s),
        .empty   (rx_empty_s),
        .count   (rx_count),
        .ovf     (rx_ovf_ev_s),
        .udf     (rx_udf_ev_s)
    );

    assign pndng    = !tx_empty_s;
    assign rx_valid = !rx_empty_s;

    // Sticky error flags; a same-cycle event takes priority over the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_ovf_r <= 1'b0;
            tx_udf_r <= 1'b0;
            rx_ovf_r <= 1'b0;
        end else begin
            tx_ovf_r <= tx_ovf_ev_s | (tx_ovf_r & !clr_status);
            tx_udf_r <= tx_udf_ev_s | (tx_udf_r & !clr_status);
            rx_ovf_r <= rx_ovf_ev_s | (rx_ovf_r & !clr_status);
        end
    end

    // Saturating count of misaddressed packets; clear plus a drop yields 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_r <= 8'd0;
        end else if (drop_ev_s) begin
            if (clr_status) begin
                drop_cnt_r <= 8'd1;
            end else if (drop_cnt_r != 8'hFF) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end else if (clr_status) begin
            drop_cnt_r <= 8'd0;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign tx_ovf      = tx_ovf_r;
    assign tx_udf      = tx_udf_r;
    assign rx_ovf      = rx_ovf_r;
    assign rx_drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_bus_dev_fifo.sv
// Testbench for bus_dev_fifo: directed scenarios plus random traffic, checked
// against a queue-based reference model of both FIFOs, the flags and counter.
module tb_bus_dev_fifo;

    localparam int         PW    = 16;
    localparam int         DEPTH = 8;
    localparam logic [7:0] MY_ID = 8'h02;

    logic          clk;
    logic          reset;
    logic          dev_wr_en;
    logic [PW-1:0] dev_wr_data;
    logic          tx_full;
    logic [3:0]    tx_count;
    logic          pndng;
    logic [PW-1:0] D_pop;
    logic          pop;
    logic          push;
    logic [PW-1:0] D_push;
    logic          dev_rd_en;
    logic [PW-1:0] dev_rd_data;
    logic          rx_valid;
    logic [3:0]    rx_count;
    logic          clr_status;
    logic          tx_ovf;
    logic          tx_udf;
    logic          rx_ovf;
    logic [7:0]    rx_drop_cnt;

    bus_dev_fifo #(.pckg_sz(PW), .depth(DEPTH), .id(MY_ID), .broadcast(8'hFF)) dut (
        .clk(clk), .reset(reset),
        .dev_wr_en(dev_wr_en), .dev_wr_data(dev_wr_data),
        .tx_full(tx_full), .tx_count(tx_count), .pndng(pndng), .D_pop(D_pop), .pop(pop),
        .push(push), .D_push(D_push),
        .dev_rd_en(dev_rd_en), .dev_rd_data(dev_rd_data), .rx_valid(rx_valid), .rx_count(rx_count),
        .clr_status(clr_status), .tx_ovf(tx_ovf), .tx_udf(tx_udf), .rx_ovf(rx_ovf),
        .rx_drop_cnt(rx_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [PW-1:0] m_tx[$];
    logic [PW-1:0] m_rx[$];
    bit            m_tx_ovf, m_tx_udf, m_rx_ovf;
    int            m_drop;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tx.delete();
        m_rx.delete();
        m_tx_ovf = 1'b0;
        m_tx_udf = 1'b0;
        m_rx_ovf = 1'b0;
        m_drop   = 0;
    endtask

    // Apply one clock of the spec rules to the model using the driven inputs.
    task automatic model_step();
        bit tx_pop_ok, tx_wr_ok, rx_rd_ok, rx_hit, rx_wr_ok;
        bit ev_tovf, ev_tudf, ev_rovf, ev_drop;
        tx_pop_ok = pop && (m_tx.size() > 0);
        tx_wr_ok  = dev_wr_en && ((m_tx.size() < DEPTH) || tx_pop_ok);
        ev_tudf   = pop && (m_tx.size() == 0);
        ev_tovf   = dev_wr_en && !tx_wr_ok;
        rx_hit    = push && ((D_push[15:8] == MY_ID) || (D_push[15:8] == 8'hFF));
        ev_drop   = push && !rx_hit;
        rx_rd_ok  = dev_rd_en && (m_rx.size() > 0);
        rx_wr_ok  = rx_hit && ((m_rx.size() < DEPTH) || rx_rd_ok);
        ev_rovf   = rx_hit && !rx_wr_ok;
        if (tx_pop_ok) void'(m_tx.pop_front());
        if (tx_wr_ok)  m_tx.push_back(dev_wr_data);
        if (rx_rd_ok)  void'(m_rx.pop_front());
        if (rx_wr_ok)  m_rx.push_back(D_push);
        m_tx_ovf = ev_tovf || (m_tx_ovf && !clr_status);
        m_tx_udf = ev_tudf || (m_tx_udf && !clr_status);
        m_rx_ovf = ev_rovf || (m_rx_ovf && !clr_status);
        if (ev_drop) m_drop = clr_status ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
        else if (clr_status) m_drop = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":pndng"},    32'(pndng),       32'(m_tx.size() != 0));
        chk({tag, ":D_pop"},    32'(D_pop),       (m_tx.size() != 0) ? 32'(m_tx[0]) : 32'd0);
        chk({tag, ":tx_count"}, 32'(tx_count),    32'(m_tx.size()));
        chk({tag, ":tx_full"},  32'(tx_full),     32'(m_tx.size() == DEPTH));
        chk({tag, ":rx_valid"}, 32'(rx_valid),    32'(m_rx.size() != 0));
        chk({tag, ":rd_data"},  32'(dev_rd_data), (m_rx.size() != 0) ? 32'(m_rx[0]) : 32'd0);
        chk({tag, ":rx_count"}, 32'(rx_count),    32'(m_rx.size()));
        chk({tag, ":tx_ovf"},   32'(tx_ovf),      32'(m_tx_ovf));
        chk({tag, ":tx_udf"},   32'(tx_udf),      32'(m_tx_udf));
        chk({tag, ":rx_ovf"},   32'(rx_ovf),      32'(m_rx_ovf));
        chk({tag, ":drop_cnt"}, 32'(rx_drop_cnt), 32'(m_drop));
    endtask

    task automatic idle_inputs();
        dev_wr_en   = 1'b0;
        dev_wr_data = 16'h0000;
        pop         = 1'b0;
        push        = 1'b0;
        D_push      = 16'h0000;
        dev_rd_en   = 1'b0;
        clr_status  = 1'b0;
    endtask

    // Inputs are already driven (at posedge+1); update model, clock, then check.
    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        idle_inputs();
        check_all(tag);
    endtask

    task automatic do_wr(input logic [PW-1:0] d, input string tag);
        dev_wr_en = 1'b1; dev_wr_data = d; step(tag);
    endtask

    task automatic do_pop(input string tag);
        pop = 1'b1; step(tag);
    endtask

    task automatic do_push(input logic [PW-1:0] d, input string tag);
        push = 1'b1; D_push = d; step(tag);
    endtask

    task automatic do_rd(input string tag);
        dev_rd_en = 1'b1; step(tag);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        reset = 1'b0;
        #12;
        check_all("reset");
        reset = 1'b1;
        @(posedge clk); #1;
        check_all("post_reset");

        // 1: single write then pop
        do_wr(16'h01AA, "t1_wr");
        chk("t1_pndng_const", 32'(pndng), 32'd1);
        chk("t1_dpop_const", 32'(D_pop), 32'h01AA);
        do_pop("t1_pop");
        chk("t1_empty_dpop", 32'(D_pop), 32'd0);

        // 2: fill, overflow, drain with wrap
        for (int i = 0; i < 8; i++) do_wr(16'(i), "t2_fill");
        chk("t2_full_const", 32'(tx_full), 32'd1);
        do_wr(16'h0008, "t2_ovf");
        chk("t2_ovf_const", 32'(tx_ovf), 32'd1);
        for (int i = 0; i < 8; i++) do_pop("t2_drain");

        // 3: full with simultaneous write and pop
        clr_status = 1'b1; step("t3_clr");
        for (int i = 0; i < 8; i++) do_wr(16'h0100 + 16'(i), "t3_fill");
        dev_wr_en = 1'b1; dev_wr_data = 16'h0009; pop = 1'b1; step("t3_wrpop_full");
        chk("t3_count_const", 32'(tx_count), 32'd8);
        chk("t3_noovf_const", 32'(tx_ovf), 32'd0);
        for (int i = 0; i < 8; i++) do_pop("t3_drain");
        // empty: write accepted, pop ignored, underflow flagged
        dev_wr_en = 1'b1; dev_wr_data = 16'h0A0A; pop = 1'b1; step("t3_wrpop_empty");
        do_pop("t3_last");

        // 4: RX filtering
        do_push(16'h0255, "t4_own");
        chk("t4_rd_const", 32'(dev_rd_data), 32'h0255);
        do_push(16'hFF10, "t4_bcast");
        do_push(16'h0310, "t4_other");
        chk("t4_drop_const", 32'(rx_drop_cnt), 32'd1);
        do_rd("t4_rd1");
        do_rd("t4_rd2");
        do_rd("t4_rd_empty");
        // RX full overflow, then full with simultaneous read
        for (int i = 0; i < 9; i++) do_push(16'h0200 + 16'(i), "t4_rxfill");
        clr_status = 1'b1; step("t4_clr");
        push = 1'b1; D_push = 16'hFF77; dev_rd_en = 1'b1; step("t4_push_rd_full");
        for (int i = 0; i < 8; i++) do_rd("t4_rxdrain");

        // 5: underflow, clear, drop saturation, clear racing a drop
        do_pop("t5_udf");
        clr_status = 1'b1; step("t5_clr");
        for (int i = 0; i < 300; i++) do_push(16'h0500 + 16'(i & 8'hFF), "t5_drops");
        chk("t5_sat_const", 32'(rx_drop_cnt), 32'd255);
        clr_status = 1'b1; push = 1'b1; D_push = 16'h0701; step("t5_clr_race");

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            int sel;
            dev_wr_en   = ($urandom_range(0, 99) < 45);
            dev_wr_data = 16'($urandom);
            pop         = ($urandom_range(0, 99) < 40);
            push        = ($urandom_range(0, 99) < 50);
            sel         = $urandom_range(0, 2);
            D_push      = {(sel == 0) ? MY_ID : (sel == 1) ? 8'hFF : 8'($urandom), 8'($urandom)};
            dev_rd_en   = ($urandom_range(0, 99) < 40);
            clr_status  = ($urandom_range(0, 99) < 5);
            step("rand");
        end

        // 6: async reset mid-cycle with traffic in flight
        clr_status = 1'b1; step("t6_clr");
        while (m_tx.size() > 0) do_pop("t6_txempty");
        while (m_rx.size() > 0) do_rd("t6_rxempty");
        for (int i = 0; i < 5; i++) do_wr(16'h0600 + 16'(i), "t6_tx");
        for (int i = 0; i < 3; i++) do_push(16'h0260 + 16'(i), "t6_rx");
        do_pop("t6_udf_setup");
        do_pop("t6_p2");
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("t6_async");
        #10;
        reset = 1'b1;
        @(posedge clk); #1;
        check_all("t6_release");
        do_wr(16'h0BEE, "t6_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
